// File: rtl/seg7_scan_driver_if.sv
`default_nettype none
//============================================================================
// Interface : seg7_scan_driver_if -- value/control inputs and display pins
// Revision  : 1.0
//============================================================================
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14
);
  logic [VAL_W-1:0]      value;
  logic                  update;
  logic                  lz_en;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [3:0]            bright;
  logic                  blank;
  logic [NUM_DIGITS-1:0] dig;
  logic [7:0]            seg;
  logic                  busy;
  logic                  ovf;

  modport master (
    output value, update, lz_en, dp_mask, bright, blank,
    input  dig, seg, busy, ovf
  );

  modport slave (
    input  value, update, lz_en, dp_mask, bright, blank,
    output dig, seg, busy, ovf
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
//============================================================================
// Module   : seg7_scan_driver -- binary to BCD (double dabble) and scanned
//            common-anode 7-segment display with blanking, dp, PWM, overflow
// Revision : 1.0
//============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int VAL_W      = 14,
  parameter int SCAN_LOG2  = 16
) (
  input  logic                clk,
  input  logic                reset,
  seg7_scan_driver_if.slave   bus
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(VAL_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               do_capture;
  logic               do_step;
  logic               do_load;

  logic [VAL_W-1:0]   cap_val;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [CNT_W-1:0]   bit_cnt;
  logic               bcd_lost;
  logic [BCD_W-1:0]   disp_bcd;
  logic               disp_ovf;
  logic               busy_reg;

  logic [SCAN_LOG2-1:0] scan_cnt;
  logic [IDX_W-1:0]     idx;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [3:0]           cur_nib;
  logic                 cur_dp;
  logic                 cur_lz;
  logic                 lit;
  logic [NUM_DIGITS-1:0] dig_nxt;
  logic [7:0]           seg_nxt;
  logic [NUM_DIGITS-1:0] dig_reg;
  logic [7:0]           seg_reg;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    do_capture = 1'b0;
    do_step    = 1'b0;
    do_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.update) begin
          do_capture = 1'b1;
          state_nxt  = ST_CONV;
        end
      end
      ST_CONV: begin
        do_step = 1'b1;
        if (bit_cnt == CNT_W'(VAL_W - 1)) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        do_load   = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
      assign bcd_adj[4*i +: 4] = (bcd_sr[4*i +: 4] >= 4'd5) ? bcd_sr[4*i +: 4] + 4'd3
                                                             : bcd_sr[4*i +: 4];
    end
  endgenerate

  // A bit carried out of the top nibble means the value needs more digits
  // than we have, which is exactly the overflow condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_val  <= '0;
      bcd_sr   <= '0;
      bit_cnt  <= '0;
      bcd_lost <= 1'b0;
      disp_bcd <= '0;
      disp_ovf <= 1'b0;
      busy_reg <= 1'b0;
    end else begin
      if (do_capture) begin
        cap_val  <= bus.value;
        bcd_sr   <= '0;
        bit_cnt  <= '0;
        bcd_lost <= 1'b0;
        busy_reg <= 1'b1;
      end
      if (do_step) begin
        cap_val  <= cap_val << 1;
        bcd_sr   <= {bcd_adj[BCD_W-2:0], cap_val[VAL_W-1]};
        bcd_lost <= bcd_lost | bcd_adj[BCD_W-1];
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (do_load) begin
        disp_bcd <= bcd_sr;
        disp_ovf <= bcd_lost;
        busy_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_LOG2'(1);
      if (scan_cnt == '1)
        idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lz
      assign upper_zero[i] = (disp_bcd[BCD_W-1:4*i] == '0);
    end
  endgenerate

  always_comb begin
    cur_nib = 4'd0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_nib = disp_bcd[4*i +: 4];
        cur_dp  = bus.dp_mask[i];
        cur_lz  = upper_zero[i] && (i != 0);
      end
    end
  end

  always_comb begin
    lit     = !bus.blank && (scan_cnt[SCAN_LOG2-1 -: 4] <= bus.bright);
    dig_nxt = lit ? ~(NUM_DIGITS'(1) << idx) : '1;
    if (disp_ovf)
      seg_nxt = 8'hBF;
    else if (bus.lz_en && cur_lz)
      seg_nxt = {~cur_dp, 7'h7F};
    else
      seg_nxt = {~cur_dp, seg_decode(cur_nib)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dig_reg <= '1;
      seg_reg <= 8'hFF;
    end else begin
      dig_reg <= dig_nxt;
      seg_reg <= seg_nxt;
    end
  end

  assign bus.dig  = dig_reg;
  assign bus.seg  = seg_reg;
  assign bus.busy = busy_reg;
  assign bus.ovf  = disp_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
//============================================================================
// Module   : tb_seg7_scan_driver -- directed self-checking bench
// Revision : 1.0
//============================================================================
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int VW = 14;
  localparam int SL = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(ND), .VAL_W(VW)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(ND), .VAL_W(VW), .SCAN_LOG2(SL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for digit i to be the active one and returns its segments.
  task automatic read_digit(input int i, output logic [7:0] s, output bit ok);
    logic [ND-1:0] want;
    want = ~(ND'(1) << i);
    ok   = 1'b0;
    s    = 8'hxx;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(posedge clk);
      #1;
      if (bus.dig === want) begin
        s  = bus.seg;
        ok = 1'b1;
      end
    end
  endtask

  task automatic convert(input logic [VW-1:0] v, output int busy_cycles);
    bus.value  = v;
    bus.update = 1'b1;
    tick(1);
    bus.update = 1'b0;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      tick(1);
    end
    tick(2);
  endtask

  task automatic test_reset();
    logic [7:0] s;
    bit ok;
    reset = 1'b1;
    tick(3);
    checks++; if (bus.dig !== 4'hF)  begin errors++; $display("FAIL rst_dig: got %h want %h", bus.dig, 4'hF); end
    checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL rst_seg: got %h want %h", bus.seg, 8'hFF); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.ovf !== 1'b0)  begin errors++; $display("FAIL rst_ovf: got %b want 0", bus.ovf); end
    reset = 1'b0;
    tick(2);
    bus.value  = 14'd1234;
    bus.update = 1'b1;
    tick(1);
    bus.update = 1'b0;
    tick(5);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL midconv_busy: got %b want 1", bus.busy); end
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    checks++; if (bus.dig !== 4'hF)  begin errors++; $display("FAIL abort_dig: got %h want %h", bus.dig, 4'hF); end
    checks++; if (bus.seg !== 8'hFF) begin errors++; $display("FAIL abort_seg: got %h want %h", bus.seg, 8'hFF); end
    tick(1);
    reset = 1'b0;
    tick(3);
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL abort_d0: got %h ok=%0d want %h", s, ok, 8'hC0); end
    read_digit(3, s, ok);
    checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL abort_d3: got %h ok=%0d want %h", s, ok, 8'hC0); end
  endtask

  task automatic test_convert();
    logic [7:0] s;
    logic [7:0] exp_seg [4];
    bit ok;
    int n;
    exp_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};  // digit 0..3 = 4,3,2,1
    convert(14'd1234, n);
    checks++; if (n != VW + 1) begin errors++; $display("FAIL conv_busy_len: got %0d want %0d", n, VW + 1); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL conv_ovf: got %b want 0", bus.ovf); end
    for (int d = 3; d >= 0; d--) begin
      read_digit(d, s, ok);
      checks++;
      if (!ok || s !== exp_seg[d]) begin
        errors++; $display("FAIL conv_d%0d: got %h ok=%0d want %h", d, s, ok, exp_seg[d]);
      end
    end
  endtask

  task automatic test_lz();
    logic [7:0] s;
    logic [7:0] exp_lz [4];
    logic [7:0] exp_nl [4];
    bit ok;
    int n;
    exp_lz = '{8'hF8, 8'h7F, 8'hFF, 8'hFF};  // digit 1 blank but dp lit
    exp_nl = '{8'hF8, 8'hC0, 8'hC0, 8'hC0};
    bus.lz_en   = 1'b1;
    bus.dp_mask = 4'b0010;
    convert(14'd7, n);
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      checks++;
      if (!ok || s !== exp_lz[d]) begin
        errors++; $display("FAIL lz_on_d%0d: got %h ok=%0d want %h", d, s, ok, exp_lz[d]);
      end
    end
    bus.lz_en   = 1'b0;
    bus.dp_mask = 4'b0000;
    tick(1);
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      checks++;
      if (!ok || s !== exp_nl[d]) begin
        errors++; $display("FAIL lz_off_d%0d: got %h ok=%0d want %h", d, s, ok, exp_nl[d]);
      end
    end
    bus.lz_en = 1'b1;
    convert(14'd0, n);
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 8'hC0) begin errors++; $display("FAIL lz_zero_d0: got %h ok=%0d want %h", s, ok, 8'hC0); end
    read_digit(1, s, ok);
    checks++; if (!ok || s !== 8'hFF) begin errors++; $display("FAIL lz_zero_d1: got %h ok=%0d want %h", s, ok, 8'hFF); end
    bus.lz_en = 1'b0;
  endtask

  task automatic test_ovf();
    logic [7:0] s;
    logic [7:0] exp_42 [4];
    bit ok;
    int n;
    exp_42 = '{8'hA4, 8'h99, 8'hC0, 8'hC0};
    bus.dp_mask = 4'hF;
    bus.lz_en   = 1'b1;
    convert(14'd12000, n);
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_12000: got %b want 1", bus.ovf); end
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 8'hBF) begin errors++; $display("FAIL ovf_d0: got %h ok=%0d want %h", s, ok, 8'hBF); end
    read_digit(3, s, ok);
    checks++; if (!ok || s !== 8'hBF) begin errors++; $display("FAIL ovf_d3: got %h ok=%0d want %h", s, ok, 8'hBF); end
    convert(14'd9999, n);
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_9999: got %b want 0", bus.ovf); end
    read_digit(0, s, ok);
    checks++; if (!ok || s !== 8'h10) begin errors++; $display("FAIL max_d0: got %h ok=%0d want %h", s, ok, 8'h10); end
    read_digit(3, s, ok);
    checks++; if (!ok || s !== 8'h10) begin errors++; $display("FAIL max_d3: got %h ok=%0d want %h", s, ok, 8'h10); end
    bus.dp_mask = 4'h0;
    bus.lz_en   = 1'b0;
    convert(14'd10000, n);
    checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_10000: got %b want 1", bus.ovf); end
    read_digit(1, s, ok);
    checks++; if (!ok || s !== 8'hBF) begin errors++; $display("FAIL ovf10k_d1: got %h ok=%0d want %h", s, ok, 8'hBF); end
    convert(14'd42, n);
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", bus.ovf); end
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      checks++;
      if (!ok || s !== exp_42[d]) begin
        errors++; $display("FAIL v42_d%0d: got %h ok=%0d want %h", d, s, ok, exp_42[d]);
      end
    end
  endtask

  task automatic test_bright();
    logic [3:0] levels [3];
    int         exp_lit [3];
    logic [3:0] inv;
    int lit;
    int bad;
    levels  = '{4'd0, 4'd7, 4'd15};
    exp_lit = '{4, 32, 64};  // lit cycles over four 16-cycle slots
    for (int l = 0; l < 3; l++) begin
      bus.bright = levels[l];
      tick(2);
      lit = 0;
      bad = 0;
      for (int k = 0; k < 64; k++) begin
        tick(1);
        inv = ~bus.dig;
        if (inv != 4'h0) lit++;
        if ((inv & (inv - 4'h1)) != 4'h0) bad++;
      end
      checks++; if (lit != exp_lit[l]) begin errors++; $display("FAIL bright%0d_lit: got %0d want %0d", levels[l], lit, exp_lit[l]); end
      checks++; if (bad != 0) begin errors++; $display("FAIL bright%0d_multi: got %0d want 0", levels[l], bad); end
    end
    bus.blank = 1'b1;
    tick(1);
    checks++; if (bus.dig !== 4'hF) begin errors++; $display("FAIL blank_next: got %h want %h", bus.dig, 4'hF); end
    lit = 0;
    for (int k = 0; k < 64; k++) begin
      tick(1);
      if (bus.dig !== 4'hF) lit++;
    end
    checks++; if (lit != 0) begin errors++; $display("FAIL blank_hold: got %0d want 0", lit); end
    bus.blank = 1'b0;
    tick(2);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    logic [7:0] exp_seg [4];
    bit ok;
    int n;
    exp_seg = '{8'h99, 8'hB0, 8'h24, 8'hF9};  // 1234, dp only on digit 2
    bus.dp_mask = 4'b0100;
    bus.value   = 14'd1234;
    bus.update  = 1'b1;
    tick(1);
    bus.update  = 1'b0;
    tick(3);
    bus.value   = 14'd5678;
    bus.update  = 1'b1;
    tick(1);
    bus.update  = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    checks++; if (n != VW + 1 - 4) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", n, VW + 1 - 4); end
    tick(2);
    for (int d = 0; d < 4; d++) begin
      read_digit(d, s, ok);
      checks++;
      if (!ok || s !== exp_seg[d]) begin
        errors++; $display("FAIL b2b_d%0d: got %h ok=%0d want %h", d, s, ok, exp_seg[d]);
      end
    end
    bus.dp_mask = 4'b0000;
  endtask

  initial begin
    reset       = 1'b1;
    bus.value   = '0;
    bus.update  = 1'b0;
    bus.lz_en   = 1'b0;
    bus.dp_mask = '0;
    bus.bright  = 4'd15;
    bus.blank   = 1'b0;
    test_reset();
    test_convert();
    test_lz();
    test_ovf();
    test_bright();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
